result_unloader: RTL

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/result_unloader_if.sv | 27 ++
 rtl/result_unloader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/result_unloader_if.sv
// Result-RAM read port and output word stream of the result unloader.
// master = unloader side, slave = RAM model / stream consumer side.
interface result_unloader_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [31:0]           RAM_RES_Do;
  logic                  RAM_RES_EN;
  logic [ADDR_WIDTH-1:0] RAM_RES_A;
  logic [3:0]            RAM_RES_WE;
  logic [31:0]           RAM_RES_Di;
  logic [31:0]           out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  RAM_RES_Do, out_ready,
    output RAM_RES_EN, RAM_RES_A, RAM_RES_WE, RAM_RES_Di,
           out_data, out_valid, out_last
  );

  modport slave (
    output RAM_RES_Do, out_ready,
    input  RAM_RES_EN, RAM_RES_A, RAM_RES_WE, RAM_RES_Di,
           out_data, out_valid, out_last
  );
endinterface

// File: rtl/result_unloader.sv
// Streams a header (vertex count) followed by vertex_count*WORDS_PER_VERTEX
// result-RAM words through a 2-entry output FIFO with valid/ready flow control.
module result_unloader #(
  parameter int ADDR_WIDTH       = 11,
  parameter int WORDS_PER_VERTEX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         vertex_count,
  output logic                busy,
  result_unloader_if.master   bus
);
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [NW-1:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [31:0]           buf_data_reg [2];
  logic [1:0]            buf_last_reg;
  logic [1:0]            count_reg;
  logic                  ret_valid_reg;
  logic                  ret_last_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [ADDR_WIDTH-1:0] last_a_reg;
  logic [NW-1:0]         n_reg;

  logic [33:0]           product;
  logic [NW-1:0]         n_start;
  logic                  start_accept;
  logic                  head_valid;
  logic [31:0]           head_data;
  logic                  head_last;
  logic                  transfer;
  logic [1:0]            occ;
  logic                  rd_en;
  logic                  rd_final;
  logic                  pop;
  logic                  push;
  logic [1:0]            wr_idx;

  assign product      = 34'(vertex_count) * 34'(WORDS_PER_VERTEX);
  assign n_start      = (product > 34'(N_MAX)) ? N_MAX : product[NW-1:0];
  assign start_accept = (state_reg == IDLE) && start;

  // An empty FIFO passes returning RAM data straight through so a word can
  // leave the cycle its data arrives; a stalled word lands in slot 0 unchanged.
  always_comb begin
    head_valid = 1'b0;
    head_data  = '0;
    head_last  = 1'b0;
    if (count_reg != 2'd0) begin
      head_valid = 1'b1;
      head_data  = buf_data_reg[0];
      head_last  = buf_last_reg[0];
    end else if (ret_valid_reg) begin
      head_valid = 1'b1;
      head_data  = bus.RAM_RES_Do;
      head_last  = ret_last_reg;
    end
  end

  assign transfer = head_valid && bus.out_ready;
  assign occ      = count_reg + {1'b0, ret_valid_reg};
  assign rd_final = ({1'b0, rd_addr_reg} == (n_reg - NW'(1)));
  assign pop      = transfer && (count_reg != 2'd0);
  assign push     = ret_valid_reg && !(transfer && (count_reg == 2'd0));
  assign wr_idx   = count_reg - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (n_start == '0) ? DRAIN : RUN;
      end
      RUN: begin
        // Held words plus in-flight reads never exceed the two FIFO slots.
        rd_en = (occ != 2'd2) || transfer;
        if (rd_en && rd_final) state_next = DRAIN;
      end
      DRAIN: begin
        if (transfer && head_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= 2'd0;
      buf_last_reg  <= 2'b00;
      ret_valid_reg <= 1'b0;
      ret_last_reg  <= 1'b0;
      rd_addr_reg   <= '0;
      last_a_reg    <= '0;
      n_reg         <= '0;
    end else begin
      ret_valid_reg <= rd_en;
      ret_last_reg  <= rd_en && rd_final;
      if (rd_en) begin
        rd_addr_reg <= rd_addr_reg + 1'b1;
        last_a_reg  <= rd_addr_reg;
      end
      if (start_accept) begin
        n_reg           <= n_start;
        rd_addr_reg     <= '0;
        buf_data_reg[0] <= vertex_count;
        buf_last_reg[0] <= (n_start == '0);
        count_reg       <= 2'd1;
      end else begin
        if (pop) begin
          buf_data_reg[0] <= buf_data_reg[1];
          buf_last_reg[0] <= buf_last_reg[1];
        end
        if (push) begin
          buf_data_reg[wr_idx[0]] <= bus.RAM_RES_Do;
          buf_last_reg[wr_idx[0]] <= ret_last_reg;
        end
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign bus.RAM_RES_EN = rd_en;
  assign bus.RAM_RES_A  = rd_en ? rd_addr_reg : last_a_reg;
  assign bus.RAM_RES_WE = 4'b0000;
  assign bus.RAM_RES_Di = 32'd0;
  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head_data;
  assign bus.out_last   = head_valid && head_last;
  assign busy           = (state_reg != IDLE);
endmodule
